// File: rtl/mem_arbiter_pkg.sv
// Shared types and widths for the two-master memory bus arbiter.
package mem_arbiter_pkg;

   localparam int ADDR_W  = 19;   // word address occupies bits [19:1]
   localparam int DATA_W  = 16;
   localparam int BSEL_W  = 2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_D = 2'd1,
      SERVE_I = 2'd2
   } state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Fixed-priority arbiter between the load/store unit (data) and the instruction
// prefetcher; the winner's request is registered and driven onto one memory bus.
module mem_arbiter
   import mem_arbiter_pkg::*;
(
   input  logic                clk,
   input  logic                reset_n,

   input  logic [ADDR_W:1]     d_m_addr,
   input  logic [DATA_W-1:0]   d_m_data_out,
   input  logic                d_m_access,
   input  logic                d_m_wr_en,
   input  logic [BSEL_W-1:0]   d_m_bytesel,
   output logic                d_m_ack,

   input  logic [ADDR_W:1]     i_m_addr,
   input  logic [DATA_W-1:0]   i_m_data_out,
   input  logic                i_m_access,
   input  logic                i_m_wr_en,
   input  logic [BSEL_W-1:0]   i_m_bytesel,
   output logic                i_m_ack,

   output logic [DATA_W-1:0]   m_data_in_out,

   output logic [ADDR_W:1]     q_m_addr,
   output logic [DATA_W-1:0]   q_m_data_out,
   output logic                q_m_access,
   output logic                q_m_wr_en,
   output logic [BSEL_W-1:0]   q_m_bytesel,
   input  logic [DATA_W-1:0]   q_m_data_in,
   input  logic                q_m_ack,

   output logic                grant_d,
   output logic                grant_i
);

   state_t state;
   state_t state_next;
   logic   load_d;
   logic   load_i;

   // NOTE: all sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state        <= IDLE;
         q_m_addr     <= '0;
         q_m_data_out <= '0;
         q_m_wr_en    <= 1'b0;
         q_m_bytesel  <= '0;
      end else begin
         state <= state_next;
         if (load_d) begin
            q_m_addr     <= d_m_addr;
            q_m_data_out <= d_m_data_out;
            q_m_wr_en    <= d_m_wr_en;
            q_m_bytesel  <= d_m_bytesel;
         end else if (load_i) begin
            q_m_addr     <= i_m_addr;
            q_m_data_out <= i_m_data_out;
            q_m_wr_en    <= i_m_wr_en;
            q_m_bytesel  <= i_m_bytesel;
         end
      end
   end

   // NOTE: every output of this block gets a default first, so no path through
   // the case statement can leave a variable unassigned and infer a latch.
   always_comb begin
      state_next = state;
      load_d     = 1'b0;
      load_i     = 1'b0;
      unique case (state)
         IDLE: begin
            if (d_m_access) begin
               state_next = SERVE_D;
               load_d     = 1'b1;
            end else if (i_m_access) begin
               state_next = SERVE_I;
               load_i     = 1'b1;
            end
         end
         SERVE_D,
         SERVE_I: begin
            // No preemption: the owner keeps the bus until memory acknowledges.
            if (q_m_ack) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign grant_d       = (state == SERVE_D);
   assign grant_i       = (state == SERVE_I);
   // Request drops in the ack cycle itself so memory never sees a second access.
   assign q_m_access    = (state != IDLE) & ~q_m_ack;
   assign d_m_ack       = q_m_ack & grant_d;
   assign i_m_ack       = q_m_ack & grant_i;
   assign m_data_in_out = q_m_data_in;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, a bounded-wait
// handshake sequence, and randomized traffic against a behavioural model.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [19:1]       d_m_addr, i_m_addr, q_m_addr;
   logic [15:0]       d_m_data_out, i_m_data_out, q_m_data_out, q_m_data_in, m_data_in_out;
   logic              d_m_access, i_m_access, d_m_wr_en, i_m_wr_en;
   logic [1:0]        d_m_bytesel, i_m_bytesel, q_m_bytesel;
   logic              d_m_ack, i_m_ack, q_m_access, q_m_wr_en, q_m_ack;
   logic              grant_d, grant_i;

   always #5 clk = ~clk;

   mem_arbiter dut (
      .clk(clk), .reset_n(reset_n),
      .d_m_addr(d_m_addr), .d_m_data_out(d_m_data_out), .d_m_access(d_m_access),
      .d_m_wr_en(d_m_wr_en), .d_m_bytesel(d_m_bytesel), .d_m_ack(d_m_ack),
      .i_m_addr(i_m_addr), .i_m_data_out(i_m_data_out), .i_m_access(i_m_access),
      .i_m_wr_en(i_m_wr_en), .i_m_bytesel(i_m_bytesel), .i_m_ack(i_m_ack),
      .m_data_in_out(m_data_in_out),
      .q_m_addr(q_m_addr), .q_m_data_out(q_m_data_out), .q_m_access(q_m_access),
      .q_m_wr_en(q_m_wr_en), .q_m_bytesel(q_m_bytesel), .q_m_data_in(q_m_data_in),
      .q_m_ack(q_m_ack), .grant_d(grant_d), .grant_i(grant_i)
   );

   typedef struct {
      logic        rst_n;
      logic        d_acc;
      logic [19:1] d_addr;
      logic [15:0] d_data;
      logic        d_we;
      logic [1:0]  d_bs;
      logic        i_acc;
      logic [19:1] i_addr;
      logic [15:0] i_data;
      logic        i_we;
      logic [1:0]  i_bs;
      logic        ack;
      logic [15:0] rdata;
   } stim_t;

   typedef struct {
      stim_t       s;
      logic        e_acc;
      logic        e_dack;
      logic        e_iack;
      logic        e_gd;
      logic        e_gi;
      logic [37:0] e_q;     // {addr, data, wr_en, bytesel}
   } vec_t;

   int    errors = 0;
   int    checks = 0;
   stim_t cur;

   // Behavioural model: who owns the bus (0 none, 1 data, 2 instruction)
   // and the request captured when ownership was handed out.
   int          owner;
   logic [37:0] mq;

   function automatic logic [37:0] pk(logic [19:1] a, logic [15:0] d, logic we, logic [1:0] bs);
      return {a, d, we, bs};
   endfunction

   function automatic stim_t st(logic rst, logic da, logic [19:1] dad, logic [15:0] dd, logic dwe,
                                logic [1:0] dbs, logic ia, logic [19:1] iad, logic ack, logic [15:0] rd);
      stim_t s;
      s.rst_n = rst; s.d_acc = da; s.d_addr = dad; s.d_data = dd; s.d_we = dwe; s.d_bs = dbs;
      s.i_acc = ia; s.i_addr = iad; s.i_data = 16'h0; s.i_we = 1'b0; s.i_bs = 2'b11;
      s.ack = ack; s.rdata = rd;
      return s;
   endfunction

   function automatic vec_t mv(stim_t s, logic acc, logic dack, logic iack, logic gd, logic gi,
                               logic [37:0] q);
      vec_t v;
      v.s = s; v.e_acc = acc; v.e_dack = dack; v.e_iack = iack; v.e_gd = gd; v.e_gi = gi; v.e_q = q;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input stim_t s);
      @(negedge clk);
      cur          = s;
      reset_n      = s.rst_n;
      d_m_access   = s.d_acc;  d_m_addr = s.d_addr; d_m_data_out = s.d_data;
      d_m_wr_en    = s.d_we;   d_m_bytesel = s.d_bs;
      i_m_access   = s.i_acc;  i_m_addr = s.i_addr; i_m_data_out = s.i_data;
      i_m_wr_en    = s.i_we;   i_m_bytesel = s.i_bs;
      q_m_ack      = s.ack;    q_m_data_in = s.rdata;
      #1;
   endtask

   task automatic model_edge();
      if (!cur.rst_n) begin
         owner = 0;
         mq    = '0;
      end else if (owner == 0) begin
         if (cur.d_acc) begin
            owner = 1; mq = pk(cur.d_addr, cur.d_data, cur.d_we, cur.d_bs);
         end else if (cur.i_acc) begin
            owner = 2; mq = pk(cur.i_addr, cur.i_data, cur.i_we, cur.i_bs);
         end
      end else if (cur.ack) begin
         owner = 0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
   endtask

   task automatic model_check(input string tag);
      check({tag, "_grant"}, {grant_d, grant_i}, {owner == 1, owner == 2});
      check({tag, "_q_access"}, q_m_access, (owner != 0) && !cur.ack);
      check({tag, "_acks"}, {d_m_ack, i_m_ack}, {cur.ack && owner == 1, cur.ack && owner == 2});
      check({tag, "_q_regs"}, pk(q_m_addr, q_m_data_out, q_m_wr_en, q_m_bytesel), mq);
      check({tag, "_rdata"}, m_data_in_out, cur.rdata);
   endtask

   vec_t  tbl[$];
   stim_t idle_s;
   stim_t s;

   initial begin
      logic [37:0] q0, qa, qd3, qi2, qw, q6, q61, q7, q8;
      q0  = '0;
      qa  = pk(19'h00100, 16'h0, 1'b0, 2'b11);
      qd3 = pk(19'h00300, 16'h0, 1'b0, 2'b11);
      qi2 = pk(19'h00200, 16'h0, 1'b0, 2'b11);
      qw  = pk(19'h00400, 16'h1234, 1'b1, 2'b10);
      q6  = pk(19'h00600, 16'h0, 1'b0, 2'b11);
      q61 = pk(19'h00601, 16'h0, 1'b0, 2'b11);
      q7  = pk(19'h00700, 16'h0, 1'b0, 2'b11);
      q8  = pk(19'h00800, 16'h0, 1'b0, 2'b11);
      idle_s = st(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 16'h0);

      // Single data read, memory acks three cycles after q_m_access rises.
      tbl.push_back(mv(st(1,1,19'h00100,0,0,2'b11,0,0,0,0),       0,0,0,0,0,q0));
      tbl.push_back(mv(st(1,1,19'h00100,0,0,2'b11,0,0,0,0),       1,0,0,1,0,qa));
      tbl.push_back(mv(st(1,1,19'h00100,0,0,2'b11,0,0,0,0),       1,0,0,1,0,qa));
      tbl.push_back(mv(st(1,1,19'h00100,0,0,2'b11,0,0,0,0),       1,0,0,1,0,qa));
      tbl.push_back(mv(st(1,1,19'h00100,0,0,2'b11,0,0,1,16'hBEEF),0,1,0,1,0,qa));
      tbl.push_back(mv(idle_s,                                    0,0,0,0,0,qa));
      // Simultaneous requests: data first, instruction at ack+2.
      tbl.push_back(mv(st(1,1,19'h00300,0,0,2'b11,1,19'h00200,0,0),       0,0,0,0,0,qa));
      tbl.push_back(mv(st(1,1,19'h00300,0,0,2'b11,1,19'h00200,0,0),       1,0,0,1,0,qd3));
      tbl.push_back(mv(st(1,1,19'h00300,0,0,2'b11,1,19'h00200,1,16'h5555),0,1,0,1,0,qd3));
      tbl.push_back(mv(st(1,0,0,0,0,2'b00,1,19'h00200,0,0),               0,0,0,0,0,qd3));
      tbl.push_back(mv(st(1,0,0,0,0,2'b00,1,19'h00200,0,0),               1,0,0,0,1,qi2));
      tbl.push_back(mv(st(1,0,0,0,0,2'b00,1,19'h00200,1,16'h7777),        0,0,1,0,1,qi2));
      tbl.push_back(mv(idle_s,                                            0,0,0,0,0,qi2));
      // Write: registered request stays put while the master's inputs change.
      tbl.push_back(mv(st(1,1,19'h00400,16'h1234,1,2'b10,0,0,0,0),   0,0,0,0,0,qi2));
      tbl.push_back(mv(st(1,1,19'h00555,16'hFFFF,0,2'b01,0,0,0,0),   1,0,0,1,0,qw));
      tbl.push_back(mv(st(1,1,19'h00555,16'hFFFF,0,2'b01,0,0,0,0),   1,0,0,1,0,qw));
      tbl.push_back(mv(st(1,1,19'h00555,16'hFFFF,0,2'b01,0,0,1,0),   0,1,0,1,0,qw));
      tbl.push_back(mv(idle_s,                                       0,0,0,0,0,qw));
      // Unaligned two-beat load with the instruction master waiting throughout.
      tbl.push_back(mv(st(1,1,19'h00600,0,0,2'b11,1,19'h00700,0,0),       0,0,0,0,0,qw));
      tbl.push_back(mv(st(1,1,19'h00600,0,0,2'b11,1,19'h00700,0,0),       1,0,0,1,0,q6));
      tbl.push_back(mv(st(1,1,19'h00600,0,0,2'b11,1,19'h00700,1,16'h0600),0,1,0,1,0,q6));
      tbl.push_back(mv(st(1,1,19'h00601,0,0,2'b11,1,19'h00700,0,0),       0,0,0,0,0,q6));
      tbl.push_back(mv(st(1,1,19'h00601,0,0,2'b11,1,19'h00700,0,0),       1,0,0,1,0,q61));
      tbl.push_back(mv(st(1,1,19'h00601,0,0,2'b11,1,19'h00700,1,16'h0601),0,1,0,1,0,q61));
      tbl.push_back(mv(st(1,0,0,0,0,2'b00,1,19'h00700,0,0),               0,0,0,0,0,q61));
      tbl.push_back(mv(st(1,0,0,0,0,2'b00,1,19'h00700,0,0),               1,0,0,0,1,q7));
      tbl.push_back(mv(st(1,0,0,0,0,2'b00,1,19'h00700,1,16'h0700),        0,0,1,0,1,q7));
      tbl.push_back(mv(idle_s,                                            0,0,0,0,0,q7));
      // One-cycle reset while serving the instruction master, then a stray ack.
      tbl.push_back(mv(st(1,0,0,0,0,2'b00,1,19'h00800,0,0),   0,0,0,0,0,q7));
      tbl.push_back(mv(st(1,0,0,0,0,2'b00,1,19'h00800,0,0),   1,0,0,0,1,q8));
      tbl.push_back(mv(st(0,0,0,0,0,2'b00,1,19'h00800,0,0),   1,0,0,0,1,q8));
      tbl.push_back(mv(st(1,0,0,0,0,2'b00,0,0,1,16'h1111),    0,0,0,0,0,q0));
      tbl.push_back(mv(idle_s,                                0,0,0,0,0,q0));

      // Reset and check reset values.
      owner = 0;
      mq    = '0;
      s = idle_s;
      s.rst_n = 1'b0;
      s.d_acc = 1'b1;
      drive(s); tick();
      drive(s); tick();
      drive(idle_s);
      check("rst_grant", {grant_d, grant_i}, 2'b00);
      check("rst_q_access", q_m_access, 1'b0);
      check("rst_acks", {d_m_ack, i_m_ack}, 2'b00);
      check("rst_q_regs", pk(q_m_addr, q_m_data_out, q_m_wr_en, q_m_bytesel), q0);
      tick();

      foreach (tbl[k]) begin
         drive(tbl[k].s);
         check($sformatf("tbl%0d_q_access", k), q_m_access, tbl[k].e_acc);
         check($sformatf("tbl%0d_acks", k), {d_m_ack, i_m_ack}, {tbl[k].e_dack, tbl[k].e_iack});
         check($sformatf("tbl%0d_grant", k), {grant_d, grant_i}, {tbl[k].e_gd, tbl[k].e_gi});
         check($sformatf("tbl%0d_q_regs", k),
               pk(q_m_addr, q_m_data_out, q_m_wr_en, q_m_bytesel), tbl[k].e_q);
         check($sformatf("tbl%0d_rdata", k), m_data_in_out, tbl[k].s.rdata);
         tick();
      end

      // Handshake with a bounded wait for q_m_access, acking two cycles later.
      begin
         int  lat;
         bit  seen;
         lat  = -1;
         seen = 1'b0;
         s = st(1, 1, 19'($urandom), 16'($urandom), 1'b1, 2'b01, 0, 0, 0, 0);
         for (int c = 0; c < 8; c++) begin
            drive(s);
            model_check("hs_wait");
            if (q_m_access === 1'b1) begin
               seen = 1'b1;
               lat  = c;
               break;
            end
            tick();
         end
         check("hs_req_seen", seen, 1'b1);
         check("hs_req_latency", lat, 1);
         if (seen) begin
            tick(); drive(s); model_check("hs_hold");
            tick();
            s.ack = 1'b1;
            s.rdata = 16'hC0DE;
            drive(s); model_check("hs_ack");
            check("hs_dack", d_m_ack, 1'b1);
            tick();
         end
         drive(idle_s); model_check("hs_idle"); tick();
      end

      // Randomized traffic against the model.
      for (int n = 0; n < 600; n++) begin
         s.rst_n  = ($urandom_range(0, 59) != 0);
         s.d_acc  = ($urandom_range(0, 2) == 0);
         s.d_addr = 19'($urandom);
         s.d_data = 16'($urandom);
         s.d_we   = 1'($urandom);
         s.d_bs   = 2'($urandom);
         s.i_acc  = ($urandom_range(0, 1) == 0);
         s.i_addr = 19'($urandom);
         s.i_data = 16'($urandom);
         s.i_we   = 1'($urandom);
         s.i_bs   = 2'($urandom);
         s.ack    = ($urandom_range(0, 3) == 0);
         s.rdata  = 16'($urandom);
         drive(s);
         model_check("rnd");
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
